// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: ALU control codes, the mult/div FSM states
// and a two's-complement magnitude helper.
package mips_pkg;

   localparam int unsigned XLEN      = 32;
   localparam int unsigned MDU_STEPS = 32;

   localparam logic [3:0] ALU_AND  = 4'b0000;
   localparam logic [3:0] ALU_OR   = 4'b0001;
   localparam logic [3:0] ALU_ADD  = 4'b0010;
   localparam logic [3:0] ALU_SUB  = 4'b0110;
   localparam logic [3:0] ALU_SLT  = 4'b0111;
   localparam logic [3:0] ALU_MULT = 4'b0011;
   localparam logic [3:0] ALU_DIV  = 4'b0100;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2
   } mdu_state;

   function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v);
      return v[XLEN-1] ? (~v + 1'b1) : v;
   endfunction

endpackage

// File: rtl/mdu_iter.sv
// Iterative unsigned engine: shift-add multiply or restoring divide,
// one bit per step over a 2*WIDTH accumulator.
module mdu_iter
   import mips_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_i,
   input  logic             div_i,
   input  logic             step_i,
   input  logic [WIDTH-1:0] opa_i,
   input  logic [WIDTH-1:0] opb_i,
   output logic             div_o,
   output logic             last_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);

   localparam int unsigned CW = $clog2(MDU_STEPS);

   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   opb_q;
   logic [CW-1:0]      cnt_q;
   logic               div_q;
   logic [WIDTH:0]     sum, trial;
   logic [2*WIDTH-1:0] shl;

   // Multiply: lower half holds the multiplier and shifts right as the product grows.
   // Divide: lower half holds the dividend and collects quotient bits from the right.
   always_comb begin
      sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opb_q & {WIDTH{acc_q[0]}}};
      shl   = {acc_q[2*WIDTH-2:0], 1'b0};
      trial = {1'b0, shl[2*WIDTH-1:WIDTH]} - {1'b0, opb_q};
      if (div_q) begin
         acc_d = trial[WIDTH] ? shl : {trial[WIDTH-1:0], shl[WIDTH-1:1], 1'b1};
      end else begin
         acc_d = {sum, acc_q[WIDTH-1:1]};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         acc_q <= '0;
         opb_q <= '0;
         cnt_q <= '0;
         div_q <= 1'b0;
      end else if (load_i) begin
         acc_q <= {{WIDTH{1'b0}}, opa_i};
         opb_q <= opb_i;
         cnt_q <= '0;
         div_q <= div_i;
      end else if (step_i) begin
         acc_q <= acc_d;
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign last_o = (cnt_q == CW'(MDU_STEPS - 1));
   assign div_o  = div_q;
   assign hi_o   = acc_q[2*WIDTH-1:WIDTH];
   assign lo_o   = acc_q[WIDTH-1:0];

endmodule

// File: rtl/mdu_alu.sv
// EX-stage execute unit: single-cycle logic/arith ops plus multi-cycle signed
// mult/div writing HI/LO, with busy/done handshake.
module mdu_alu
   import mips_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [3:0]       control,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             start,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero
);

   mdu_state state_q, state_d;
   logic [WIDTH-1:0] result_q, result_d, hi_q, hi_d, lo_q, lo_d;
   logic             zero_q, zero_d, done_q, done_d, dbz_q, dbz_d;
   logic             qneg_q, qneg_d, rneg_q, rneg_d;

   logic             it_load, it_step, it_div, it_div_mode, it_last;
   logic [WIDTH-1:0] it_hi, it_lo, simple, quo, rem;
   logic [2*WIDTH-1:0] prod;

   mdu_iter #(.WIDTH(WIDTH)) u_iter (
      .clk    (clk),
      .reset  (reset),
      .load_i (it_load),
      .div_i  (it_div),
      .step_i (it_step),
      .opa_i  (mag(a)),
      .opb_i  (mag(b)),
      .div_o  (it_div_mode),
      .last_o (it_last),
      .hi_o   (it_hi),
      .lo_o   (it_lo)
   );

   always_comb begin
      unique case (control)
         ALU_AND: simple = a & b;
         ALU_OR:  simple = a | b;
         ALU_ADD: simple = a + b;
         ALU_SUB: simple = a - b;
         ALU_SLT: simple = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         default: simple = '0;
      endcase
   end

   always_comb begin
      prod = qneg_q ? -{it_hi, it_lo} : {it_hi, it_lo};
      quo  = qneg_q ? -it_lo : it_lo;
      rem  = rneg_q ? -it_hi : it_hi;
   end

   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      zero_d   = zero_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      dbz_d    = dbz_q;
      qneg_d   = qneg_q;
      rneg_d   = rneg_q;
      done_d   = 1'b0;
      it_load  = 1'b0;
      it_step  = 1'b0;
      it_div   = (control == ALU_DIV);
      unique case (state_q)
         IDLE: begin
            if (start) begin
               if (control == ALU_MULT || (control == ALU_DIV && b != '0)) begin
                  it_load = 1'b1;
                  qneg_d  = a[WIDTH-1] ^ b[WIDTH-1];
                  rneg_d  = a[WIDTH-1];
                  dbz_d   = 1'b0;
                  state_d = RUN;
               end else if (control == ALU_DIV) begin
                  dbz_d  = 1'b1;
                  done_d = 1'b1;
               end else begin
                  result_d = simple;
                  zero_d   = (simple == '0);
                  dbz_d    = 1'b0;
                  done_d   = 1'b1;
               end
            end
         end
         RUN: begin
            it_step = 1'b1;
            if (it_last) state_d = FIX;
         end
         FIX: begin
            if (it_div_mode) begin
               hi_d     = rem;
               lo_d     = quo;
               result_d = quo;
               zero_d   = (quo == '0);
            end else begin
               hi_d     = prod[2*WIDTH-1:WIDTH];
               lo_d     = prod[WIDTH-1:0];
               result_d = prod[WIDTH-1:0];
               zero_d   = (prod[WIDTH-1:0] == '0);
            end
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         result_q <= '0;
         zero_q   <= 1'b1;
         hi_q     <= '0;
         lo_q     <= '0;
         done_q   <= 1'b0;
         dbz_q    <= 1'b0;
         qneg_q   <= 1'b0;
         rneg_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         zero_q   <= zero_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         done_q   <= done_d;
         dbz_q    <= dbz_d;
         qneg_q   <= qneg_d;
         rneg_q   <= rneg_d;
      end
   end

   assign result      = result_q;
   assign zero        = zero_q;
   assign hi          = hi_q;
   assign lo          = lo_q;
   assign busy        = (state_q != IDLE);
   assign done        = done_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mdu_alu.sv
// Scoreboard bench for mdu_alu: expected results are queued at issue time
// and compared whenever the unit pulses done.
module tb_mdu_alu;

   logic        clk = 1'b0;
   logic        reset, start;
   logic [3:0]  ctl;
   logic [31:0] op_a, op_b;
   logic [31:0] result, hi, lo;
   logic        zero, busy, done, div_by_zero;

   typedef struct {
      logic [31:0] res, hi, lo;
      logic        zero, dbz;
      int          lat, bsy, acc;
   } exp_t;

   exp_t        sbq[$];
   exp_t        got;
   int          n_cmp = 0, n_err = 0, cyc = 0, busy_run = 0;
   logic [31:0] mdl_res, mdl_hi, mdl_lo;
   logic        mdl_zero;

   mdu_alu #(.WIDTH(32)) dut (
      .clk         (clk),
      .reset       (reset),
      .control     (ctl),
      .a           (op_a),
      .b           (op_b),
      .start       (start),
      .result      (result),
      .zero        (zero),
      .hi          (hi),
      .lo          (lo),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic check_rst();
      chk("rst_result", result, 0);
      chk("rst_zero", zero, 1);
      chk("rst_hi", hi, 0);
      chk("rst_lo", lo, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_dbz", div_by_zero, 0);
   endtask

   // Called at a falling edge; returns at the next falling edge with start low.
   task automatic issue_op(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y);
      exp_t   e;
      longint sx, sy, p;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      e.lat = 0; e.bsy = 0; e.dbz = 1'b0;
      case (c)
         4'b0011: begin
            p = sx * sy;
            mdl_hi = p[63:32]; mdl_lo = p[31:0];
            mdl_res = mdl_lo; mdl_zero = (mdl_lo == 0);
            e.lat = 33; e.bsy = 33;
         end
         4'b0100: begin
            if (y == 0) e.dbz = 1'b1;
            else begin
               p = sx / sy; mdl_lo = p[31:0];
               p = sx % sy; mdl_hi = p[31:0];
               mdl_res = mdl_lo; mdl_zero = (mdl_lo == 0);
               e.lat = 33; e.bsy = 33;
            end
         end
         4'b0000: mdl_res = x & y;
         4'b0001: mdl_res = x | y;
         4'b0010: mdl_res = x + y;
         4'b0110: mdl_res = x - y;
         4'b0111: mdl_res = (sx < sy) ? 32'd1 : 32'd0;
         default: mdl_res = 32'd0;
      endcase
      if (c != 4'b0011 && c != 4'b0100) mdl_zero = (mdl_res == 0);
      e.res = mdl_res; e.zero = mdl_zero; e.hi = mdl_hi; e.lo = mdl_lo;
      e.acc = cyc + 1;
      sbq.push_back(e);
      ctl = c; op_a = x; op_b = y; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      ctl = 4'($urandom); op_a = $urandom; op_b = $urandom;
   endtask

   task automatic wait_idle();
      bit ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (sbq.size() == 0 && !busy) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      if (!ok) chk("idle_timeout", 0, 1);
   endtask

   always @(negedge clk) begin
      if (reset) busy_run = 0;
      else begin
         if (busy) busy_run++;
         if (done) begin
            if (sbq.size() == 0) chk("spurious_done", 1, 0);
            else begin
               got = sbq.pop_front();
               chk("result", result, got.res);
               chk("zero", zero, got.zero);
               chk("hi", hi, got.hi);
               chk("lo", lo, got.lo);
               chk("div_by_zero", div_by_zero, got.dbz);
               chk("latency", cyc - got.acc, got.lat);
               chk("busy_cycles", busy_run, got.bsy);
            end
            busy_run = 0;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bit seen;
      reset = 1'b1; start = 1'b0; ctl = '0; op_a = '0; op_b = '0;
      mdl_res = '0; mdl_hi = '0; mdl_lo = '0; mdl_zero = 1'b1;
      repeat (3) @(negedge clk);
      check_rst();
      reset = 1'b0;
      @(negedge clk);

      // Back-to-back single-cycle ops, including an undefined code
      issue_op(4'b0010, 32'd5, 32'hFFFF_FFFB);
      issue_op(4'b0111, 32'hFFFF_FFFF, 32'd1);
      issue_op(4'b0110, 32'd3, 32'd7);
      issue_op(4'b0000, 32'hF0F0_1234, 32'hFF00_FF00);
      issue_op(4'b0001, 32'h0F0F_0000, 32'h0000_00F0);
      issue_op(4'b0111, 32'd1, 32'hFFFF_FFFF);
      issue_op(4'b1111, 32'd1, 32'd2);
      wait_idle();

      // mult with an ignored start mid-run
      issue_op(4'b0011, 32'hFFFF_FFFD, 32'd7);
      repeat (8) @(negedge clk);
      ctl = 4'b0010; op_a = 32'd1; op_b = 32'd1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_idle();

      // start in the same cycle as done is accepted
      issue_op(4'b0011, 32'h8000_0000, 32'h8000_0000);
      seen = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (done) begin seen = 1'b1; break; end
      end
      if (!seen) chk("done_timeout", 0, 1);
      issue_op(4'b0010, 32'd7, 32'd8);
      wait_idle();

      for (int i = 0; i < 4; i++) begin
         issue_op(4'b0011, $urandom, $urandom);
         wait_idle();
         issue_op(4'b0100, $urandom, ($urandom >> (i * 8)) | 32'd1);
         wait_idle();
      end

      issue_op(4'b0100, 32'hFFFF_FFF9, 32'd2);
      wait_idle();
      issue_op(4'b0100, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_idle();
      issue_op(4'b0100, 32'd9, 32'd0);
      wait_idle();
      issue_op(4'b0001, 32'd0, 32'd0);
      wait_idle();

      // Reset mid-mult aborts and beats a simultaneous start
      issue_op(4'b0100, 32'd100, 32'd7);
      wait_idle();
      issue_op(4'b0011, 32'd12345, 32'hFFFF_FD5A);
      repeat (14) @(negedge clk);
      reset = 1'b1; start = 1'b1; ctl = 4'b0010; op_a = 32'd1; op_b = 32'd1;
      sbq.delete();
      mdl_res = '0; mdl_hi = '0; mdl_lo = '0; mdl_zero = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check_rst();
      reset = 1'b0;
      repeat (40) @(negedge clk);
      issue_op(4'b0010, 32'd1, 32'd1);
      wait_idle();
      repeat (2) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
